// File: rtl/pc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE sequencer that drives the PC jump controls.
// Any cycle that does not advance the PC reloads pc_in, because the PC self-increments.
module pc_sequencer #(
  parameter int AW          = 5,
  parameter int STACK_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc_in,
  input  logic          instr_valid,
  input  logic [2:0]    op_in,
  input  logic [AW-1:0] target_in,
  input  logic          cond_in,
  input  logic          mem_busy,
  input  logic          resume,
  output logic          pc_write,
  output logic [AW-1:0] new_pc,
  output logic          ir_load,
  output logic          exec_en,
  output logic          halted,
  output logic          fault,
  output logic [2:0]    state
);

  localparam int PW = $clog2(STACK_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] OP_SEQ  = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_BR   = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;
  localparam logic [2:0] OP_HALT = 3'd5;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_WAIT    = 3'd3,
    S_HALTED  = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    op_q;
  logic [AW-1:0] tgt_q;
  logic          cond_q;
  logic          exec_en_q, halted_q, fault_q;

  logic [AW-1:0] stk_q [STACK_DEPTH];
  logic [CW-1:0] cnt_q;
  logic [PW-1:0] top_idx;
  logic          full, empty, push, pop;

  assign top_idx = cnt_q[PW-1:0] - PW'(1);
  assign full    = (cnt_q == CW'(STACK_DEPTH));
  assign empty   = (cnt_q == '0);

  always_comb begin
    pc_write = 1'b1;
    new_pc   = pc_in;
    ir_load  = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    state_d  = state_q;
    unique case (state_q)
      S_FETCH: begin
        ir_load = instr_valid;
        if (instr_valid) state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE, S_WAIT: begin
        if (mem_busy) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_FETCH;
          case (op_q)
            OP_JMP: new_pc = tgt_q;
            OP_BR: begin
              if (cond_q) new_pc = tgt_q;
              else        pc_write = 1'b0;
            end
            OP_CALL: begin
              if (full) begin
                state_d = S_FAULT;
              end else begin
                push   = 1'b1;
                new_pc = tgt_q;
              end
            end
            OP_RET: begin
              if (empty) begin
                state_d = S_FAULT;
              end else begin
                pop    = 1'b1;
                new_pc = stk_q[top_idx];
              end
            end
            OP_HALT: state_d = S_HALTED;
            default: pc_write = 1'b0;  // SEQ and the unused 11x codes
          endcase
        end
      end
      S_HALTED: begin
        // Releasing lets the PC increment past the HALT instruction.
        if (resume) begin
          pc_write = 1'b0;
          state_d  = S_FETCH;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      op_q      <= OP_SEQ;
      tgt_q     <= '0;
      cond_q    <= 1'b0;
      cnt_q     <= '0;
      exec_en_q <= 1'b0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      exec_en_q <= (state_d == S_EXECUTE);
      halted_q  <= (state_d == S_HALTED);
      fault_q   <= fault_q | (state_d == S_FAULT);
      if (state_q == S_DECODE) begin
        op_q   <= op_in;
        tgt_q  <= target_in;
        cond_q <= cond_in;
      end
      if (push)     cnt_q <= cnt_q + CW'(1);
      else if (pop) cnt_q <= cnt_q - CW'(1);
    end
  end

  // Contents need no reset: the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) stk_q[cnt_q[PW-1:0]] <= pc_in + AW'(1);
  end

  assign exec_en = exec_en_q;
  assign halted  = halted_q;
  assign fault   = fault_q;
  assign state   = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench: table of single instructions run against a PC/imem model,
// expectations queued on issue and compared on completion, plus hand-written corner sequences.
module tb_pc_sequencer;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] pc;
  logic          instr_valid, cond_in, mem_busy, resume;
  logic [2:0]    op_in;
  logic [AW-1:0] target_in;
  logic          pc_write, ir_load, exec_en, halted, fault;
  logic [AW-1:0] new_pc;
  logic [2:0]    state;

  logic          ld_en;
  logic [AW-1:0] ld_val;
  logic [2:0]    op_mem  [32];
  logic [AW-1:0] tgt_mem [32];
  logic          cnd_mem [32];

  int total = 0;
  int bad   = 0;

  typedef struct {
    int start; int op; int tgt; int cnd; int stall;
    int epc; int est; int ecyc;
  } vec_t;

  typedef struct { int pc; int st; int cyc; } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  pc_sequencer #(.AW(AW), .STACK_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .pc_in(pc), .instr_valid(instr_valid),
    .op_in(op_in), .target_in(target_in), .cond_in(cond_in),
    .mem_busy(mem_busy), .resume(resume), .pc_write(pc_write),
    .new_pc(new_pc), .ir_load(ir_load), .exec_en(exec_en),
    .halted(halted), .fault(fault), .state(state)
  );

  // PC register the sequencer controls: increments unless jump-enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         pc <= '0;
    else if (ld_en)    pc <= ld_val;
    else if (pc_write) pc <= new_pc;
    else               pc <= pc + AW'(1);
  end

  assign op_in     = op_mem[pc];
  assign target_in = tgt_mem[pc];
  assign cond_in   = cnd_mem[pc];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input int s, input int o, input int t, input int c, input int st,
                     input int epc, input int est, input int ecyc);
    vec_t v;
    v.start = s; v.op = o; v.tgt = t; v.cnd = c; v.stall = st;
    v.epc = epc; v.est = est; v.ecyc = ecyc;
    tbl.push_back(v);
  endtask

  task automatic load_pc(input int v);
    instr_valid = 1'b0;
    ld_en  = 1'b1;
    ld_val = AW'(v);
    @(posedge clk);
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Apply one table row; assumes we are at a negedge with the DUT in FETCH.
  task automatic run_row(input int idx);
    vec_t v;
    exp_t e, g;
    int busy, cyc, ex;
    bit hold_bad, adv, done;
    v = tbl[idx];
    op_mem[v.start]  = 3'(v.op);
    tgt_mem[v.start] = AW'(v.tgt);
    cnd_mem[v.start] = v.cnd[0];
    load_pc(v.start);
    e.pc = v.epc; e.st = v.est; e.cyc = v.ecyc;
    sb.push_back(e);
    busy = v.stall; cyc = 0; ex = 0; hold_bad = 0; done = 0;
    instr_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      mem_busy = ((state == 3'd2 || state == 3'd3) && busy > 0);
      if (mem_busy) busy--;
      #1;
      if (exec_en) ex++;
      cyc++;
      adv = (state == 3'd2 || state == 3'd3) && !mem_busy;
      if (!adv && (pc_write !== 1'b1 || new_pc !== pc)) hold_bad = 1;
      if (state == 3'd0 && ir_load !== instr_valid) hold_bad = 1;
      @(posedge clk);
      @(negedge clk);
      if (adv) begin done = 1; break; end
    end
    instr_valid = 1'b0;
    mem_busy    = 1'b0;
    g = sb.pop_front();
    if (!done) chk($sformatf("row%0d timeout", idx), 0, 1);
    chk($sformatf("row%0d pc", idx), int'(pc), g.pc);
    chk($sformatf("row%0d state", idx), int'(state), g.st);
    chk($sformatf("row%0d cycles", idx), cyc, g.cyc);
    chk($sformatf("row%0d exec_en pulses", idx), ex, 1);
    chk($sformatf("row%0d hold", idx), int'(hold_bad), 0);
    chk($sformatf("row%0d halted", idx), int'(halted), int'(g.st == 4));
    chk($sformatf("row%0d fault", idx), int'(fault), int'(g.st == 5));
  endtask

  task automatic do_reset(input string nm);
    reset = 1'b1;
    #1;
    chk({nm, " state"}, int'(state), 0);
    chk({nm, " pc"}, int'(pc), 0);
    chk({nm, " fault"}, int'(fault), 0);
    chk({nm, " halted"}, int'(halted), 0);
    chk({nm, " exec_en"}, int'(exec_en), 0);
    chk({nm, " pc_write"}, int'(pc_write), 1);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic frozen(input string nm, input int epc, input int est);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 2) begin
        chk({nm, " pc"}, int'(pc), epc);
        chk({nm, " state"}, int'(state), est);
        chk({nm, " exec_en"}, int'(exec_en), 0);
        chk({nm, " pc_write"}, int'(pc_write), 1);
      end
    end
  endtask

  initial begin
    int n_a, n_b, n_c, cur;
    bit seen;
    for (int i = 0; i < 32; i++) begin
      op_mem[i] = 3'd0; tgt_mem[i] = '0; cnd_mem[i] = 1'b0;
    end
    reset = 1'b1; instr_valid = 1'b1; mem_busy = 1'b0; resume = 1'b0;
    ld_en = 1'b0; ld_val = '0;
    #1;
    chk("reset ir_load", int'(ir_load), 1);
    instr_valid = 1'b0;
    #1;
    chk("reset ir_load idle", int'(ir_load), 0);
    do_reset("reset");

    //  start op tgt c stall  exp_pc st cyc
    add(0,  0, 0,  0, 0,  1,  0, 3);
    add(1,  0, 0,  0, 0,  2,  0, 3);
    add(2,  0, 0,  0, 0,  3,  0, 3);
    add(3,  1, 17, 0, 0,  17, 0, 3);
    add(17, 2, 5,  0, 0,  18, 0, 3);
    add(18, 2, 5,  1, 0,  5,  0, 3);
    add(6,  3, 20, 0, 0,  20, 0, 3);
    add(20, 4, 0,  0, 0,  7,  0, 3);
    add(7,  0, 0,  0, 3,  8,  0, 6);
    add(8,  1, 2,  0, 1,  2,  0, 4);
    add(31, 0, 0,  0, 0,  0,  0, 3);
    add(4,  6, 9,  1, 0,  5,  0, 3);
    add(5,  7, 9,  1, 0,  6,  0, 3);
    add(31, 3, 10, 0, 0,  10, 0, 3);
    add(10, 4, 0,  0, 0,  0,  0, 3);
    add(12, 2, 25, 1, 2,  25, 0, 5);
    add(31, 5, 0,  0, 0,  31, 4, 3);
    n_a = tbl.size();
    add(1,  3, 2,  0, 0,  2,  0, 3);
    add(2,  3, 3,  0, 0,  3,  0, 3);
    add(3,  3, 4,  0, 0,  4,  0, 3);
    add(4,  3, 5,  0, 0,  5,  0, 3);
    add(5,  4, 0,  0, 0,  5,  0, 3);
    add(5,  3, 6,  0, 0,  6,  0, 3);
    add(6,  3, 9,  0, 0,  6,  5, 3);
    n_b = tbl.size();
    add(9,  4, 0,  0, 0,  9,  5, 3);
    n_c = tbl.size();
    add(0,  0, 0,  0, 0,  1,  0, 3);

    @(negedge clk);
    for (int i = 0; i < n_a - 1; i++) run_row(i);

    // resume outside HALTED must not move anything
    cur = int'(pc);
    resume = 1'b1;
    repeat (2) @(negedge clk);
    chk("resume ignored state", int'(state), 0);
    chk("resume ignored pc", int'(pc), cur);
    chk("resume ignored halted", int'(halted), 0);
    resume = 1'b0;

    run_row(n_a - 1);
    frozen("halted", 31, 4);
    chk("halted flag", int'(halted), 1);
    resume = 1'b1;
    #1;
    chk("resume pc_write", int'(pc_write), 0);
    @(negedge clk);
    resume = 1'b0;
    chk("resume pc wrap", int'(pc), 0);
    chk("resume halted", int'(halted), 0);
    chk("resume state", int'(state), 0);

    for (int i = n_a; i < n_b; i++) run_row(i);
    frozen("overflow", 6, 5);
    do_reset("overflow reset");

    for (int i = n_b; i < n_c; i++) run_row(i);
    frozen("underflow", 9, 5);
    do_reset("underflow reset");

    // reset in the middle of a stall abandons the instruction
    op_mem[12] = 3'd0;
    load_pc(12);
    instr_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (state == 3'd2) seen = 1;
      else @(negedge clk);
    end
    chk("stall reach execute", int'(seen), 1);
    mem_busy = 1'b1;
    repeat (2) @(negedge clk);
    chk("stall state", int'(state), 3);
    chk("stall pc", int'(pc), 12);
    #2;
    reset = 1'b1;
    #1;
    chk("midstall reset state", int'(state), 0);
    chk("midstall reset pc", int'(pc), 0);
    chk("midstall reset exec_en", int'(exec_en), 0);
    @(negedge clk);
    reset = 1'b0; mem_busy = 1'b0; instr_valid = 1'b0;
    @(negedge clk);

    for (int i = n_c; i < tbl.size(); i++) run_row(i);
    chk("scoreboard drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle instruction sequencer that owns the program counter's update controls. Runs a FETCH/DECODE/EXECUTE loop, drives the PC's jump-enable and jump-address inputs, and resolves jumps, conditional branches, calls/returns (small return-address stack), halt/resume and memory stalls. Because the PC increments on every clock without jump-enable, every non-advancing cycle must explicitly reload the current PC.

## Interface
- AW, 5, PC/address width (32 instructions)
- STACK_DEPTH, 4, return-address stack entries (power of two, ≥2)

- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high
- pc_in  input  AW  current PC value from the PC register
- instr_valid  input  1  instruction word at pc_in is available from instruction memory
- op_in  input  3  decoded opcode: 000 SEQ, 001 JMP, 010 BR, 011 CALL, 100 RET, 101 HALT, 11x treated as SEQ
- target_in  input  AW  jump/branch/call target
- cond_in  input  1  branch condition (BR taken when 1)
- mem_busy  input  1  execute-stage stall request
- resume  input  1  leaves HALTED
- pc_write  output  1  PC jump-enable (combinational)
- new_pc  output  AW  PC jump address (combinational)
- ir_load  output  1  instruction-register load strobe (combinational)
- exec_en  output  1  datapath execute strobe
- halted  output  1  sequencer is in HALTED
- fault  output  1  sticky stack overflow/underflow flag
- state  output  3  current FSM state, for debug

## Operation
- States: FETCH=0, DECODE=1, EXECUTE=2, WAIT_MEM=3, HALTED=4, FAULT=5.
- Hold rule: in every cycle that does not advance the PC, pc_write=1, new_pc=pc_in.
- FETCH: ir_load=instr_valid; hold. instr_valid=1 → DECODE, else stay.
- DECODE: register op_in, target_in, cond_in; hold; → EXECUTE.
- EXECUTE: exec_en=1. mem_busy=1 → hold, → WAIT_MEM. Else perform the advance (below), → FETCH.
- WAIT_MEM: exec_en=0, hold while mem_busy=1; first cycle with mem_busy=0 → advance, → FETCH.
- Advance by latched op:
  - SEQ: pc_write=0 (PC increments).
  - JMP: pc_write=1, new_pc=target.
  - BR: taken → as JMP, else as SEQ.
  - CALL: push (pc_in+1) mod 2^AW, jump to target. If stack already full: no push, hold, → FAULT.
  - RET: pop, new_pc=popped value. If stack empty: hold, → FAULT.
  - HALT: hold, → HALTED (advance is deferred).
- HALTED: halted=1, hold. resume=1 → pc_write=0 (steps past HALT), → FETCH. resume in any other state is ignored.
- FAULT: fault=1, hold forever; only reset exits.
- Stack: LIFO of STACK_DEPTH entries, internal pointer/count; contents not visible.

## Timing
- Reset (asynchronous): state=FETCH, stack empty, halted=0, fault=0, exec_en=0, latched op=SEQ. Combinational outputs immediately follow FETCH: pc_write=1, new_pc=pc_in, ir_load=instr_valid.
- Minimum instruction: 3 cycles (FETCH with instr_valid=1, DECODE, EXECUTE); PC changes on the clock edge that ends EXECUTE or the last WAIT_MEM cycle.
- Each mem_busy cycle in EXECUTE/WAIT_MEM adds exactly one cycle; mem_busy is ignored in other states.
- exec_en is high for exactly one cycle per instruction (the EXECUTE cycle), including HALT, faulting CALL/RET, and stalled instructions.
- Wrap: SEQ at PC=2^AW−1 → 0; CALL at 2^AW−1 pushes 0.
- Exactly STACK_DEPTH nested CALLs succeed; the next CALL faults. RET with a full stack is legal.
- Reset mid-instruction or mid-stall abandons it; no partial push/pop is retained.

## Test plan
- Reset, instr_valid=1, four SEQ ops → PC 0,0,0,1,1,1,2,… ; exec_en pulses every 3rd cycle; pc_write=1 in FETCH/DECODE.
- JMP target=17 at PC=3 → PC=17 after EXECUTE; BR cond=0 at 17 → 18; BR cond=1 target=5 → 5.
- CALL target=20 at PC=6, RET at 20 → PC 20 then 7; five nested CALLs with STACK_DEPTH=4 → fault=1, state=5, PC frozen at fifth CALL address.
- RET with empty stack at PC=9 → fault=1, PC stays 9 until reset; reset clears fault, PC=0.
- EXECUTE with mem_busy held 3 cycles → instruction takes 6 cycles, PC unchanged until mem_busy drops, exec_en single pulse.
- HALT at PC=31 → halted=1, PC holds 31; resume while not halted ignored; resume in HALTED → PC wraps to 0, halted=0, fetching resumes.
